// File: rtl/seq_det_session_ctrl.sv
// Session controller around a serial pattern matcher.
// A session is armed with a match target and a bit timeout. Bits arrive over
// a valid/ready handshake, and overlapping matches are counted. The session
// ends with a one-cycle done pulse and a status code: hit, timeout or abort.
module seq_det_session_ctrl #(
  parameter int unsigned     PLEN    = 12,
  parameter logic [PLEN-1:0] PATTERN = 12'b111000000111,
  parameter int unsigned     CNT_W   = 8,
  parameter int unsigned     TO_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] target_i,
  input  logic [TO_W-1:0]  timeout_i,
  input  logic             bit_valid_i,
  input  logic             x_i,
  output logic             bit_ready_o,
  output logic             det_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [CNT_W-1:0] match_cnt_o
);

  localparam int unsigned       FILL_W   = $clog2(PLEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PLEN);

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_HIT   = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [TO_W-1:0]   timeout_q, timeout_d;
  logic [PLEN-1:0]   shreg_q, shreg_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [TO_W-1:0]   bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        status_q, status_d;
  logic              det_q, det_d;

  logic              accept;
  logic              take;
  logic [PLEN-1:0]   shifted;
  logic [FILL_W-1:0] fill_inc;
  logic [TO_W-1:0]   bit_inc;
  logic [CNT_W-1:0]  cnt_inc;
  logic              match;
  logic              hit;
  logic              tmo;

  // Handshake decode and termination terms for the bit on the wire
  always_comb begin
    accept   = bit_valid_i & bit_ready_o;
    // an aborting bit is discarded: it neither shifts nor matches
    take     = accept & ~abort_i;
    shifted  = {shreg_q[PLEN-2:0], x_i};
    fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
    bit_inc  = (bitcnt_q == '1) ? bitcnt_q : bitcnt_q + TO_W'(1);
    cnt_inc  = cnt_q + CNT_W'(1);
    match    = take & (fill_inc == FILL_MAX) & (shifted == PATTERN);
    hit      = match & (cnt_inc == target_q);
    tmo      = take & (timeout_q != '0) & (bit_inc == timeout_q);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_ARM;
      S_ARM: begin
        if ((target_q == '0) || abort_i) state_d = S_DONE;
        else                             state_d = S_RUN;
      end
      S_RUN:  if (abort_i || hit || tmo) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only
  always_comb begin
    busy_o      = (state_q == S_ARM) || (state_q == S_RUN);
    bit_ready_o = (state_q == S_RUN);
    done_o      = (state_q == S_DONE);
  end

  // Datapath next-state: session setup, bit shifting, match counting, status
  always_comb begin
    target_d  = target_q;
    timeout_d = timeout_q;
    shreg_d   = shreg_q;
    fill_d    = fill_q;
    bitcnt_d  = bitcnt_q;
    cnt_d     = cnt_q;
    status_d  = status_q;
    det_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          target_d  = target_i;
          timeout_d = timeout_i;
          shreg_d   = '0;
          fill_d    = '0;
          bitcnt_d  = '0;
          cnt_d     = '0;
          status_d  = ST_NONE;
        end
      end
      S_ARM: begin
        if (target_q == '0) status_d = ST_HIT;
        else if (abort_i)   status_d = ST_ABORT;
      end
      S_RUN: begin
        if (take) begin
          shreg_d  = shifted;
          fill_d   = fill_inc;
          bitcnt_d = bit_inc;
        end
        if (match) begin
          det_d = 1'b1;
          cnt_d = cnt_inc;
        end
        if (abort_i)  status_d = ST_ABORT;
        else if (hit) status_d = ST_HIT;
        else if (tmo) status_d = ST_TMO;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q  <= '0;
      timeout_q <= '0;
      shreg_q   <= '0;
      fill_q    <= '0;
      bitcnt_q  <= '0;
      cnt_q     <= '0;
      status_q  <= ST_NONE;
      det_q     <= 1'b0;
    end else begin
      target_q  <= target_d;
      timeout_q <= timeout_d;
      shreg_q   <= shreg_d;
      fill_q    <= fill_d;
      bitcnt_q  <= bitcnt_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      det_q     <= det_d;
    end
  end

  assign det_o       = det_q;
  assign status_o    = status_q;
  assign match_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_det_session_ctrl.sv
// Directed bench for seq_det_session_ctrl with hand-computed expectations.
module tb_seq_det_session_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       abort_i;
  logic [7:0] target_i;
  logic [15:0] timeout_i;
  logic       bit_valid_i;
  logic       x_i;
  logic       bit_ready_o;
  logic       det_o;
  logic       busy_o;
  logic       done_o;
  logic [1:0] status_o;
  logic [7:0] match_cnt_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned dets;
  logic        early;

  seq_det_session_ctrl #(
    .PLEN(12),
    .PATTERN(12'b111000000111),
    .CNT_W(8),
    .TO_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .abort_i(abort_i),
    .target_i(target_i),
    .timeout_i(timeout_i),
    .bit_valid_i(bit_valid_i),
    .x_i(x_i),
    .bit_ready_o(bit_ready_o),
    .det_o(det_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .status_o(status_o),
    .match_cnt_o(match_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start a session and step through ARM into RUN
  task automatic start_session(input logic [7:0] tgt, input logic [15:0] tmo);
    start_i   = 1'b1;
    target_i  = tgt;
    timeout_i = tmo;
    tick();
    start_i = 1'b0;
    tick();
  endtask

  // feed n bits MSB-first; abort_i is raised together with the last bit if asked
  task automatic feed(input logic [31:0] bits, input int unsigned n, input logic abort_last,
                      output int unsigned ndet, output logic early_done);
    logic [31:0] b;
    ndet = 0;
    early_done = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      b = bits >> (n - 1 - i);
      bit_valid_i = 1'b1;
      x_i = b[0];
      abort_i = abort_last && (i == n - 1);
      tick();
      if (det_o) ndet++;
      if (done_o && (i != n - 1)) early_done = 1'b1;
    end
    bit_valid_i = 1'b0;
    x_i = 1'b0;
    abort_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; target_i = '0; timeout_i = '0;
    bit_valid_i = 1'b0; x_i = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_ready", {31'd0, bit_ready_o}, 32'd0);
    chk("rst_status", {30'd0, status_o}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: single match, target 1
    start_i = 1'b1; target_i = 8'd1; timeout_i = 16'd0;
    tick();
    start_i = 1'b0;
    chk("t1_arm_busy", {31'd0, busy_o}, 32'd1);
    chk("t1_arm_ready", {31'd0, bit_ready_o}, 32'd0);
    tick();
    chk("t1_run_ready", {31'd0, bit_ready_o}, 32'd1);
    feed(32'b111000000111, 12, 1'b0, dets, early);
    chk("t1_early", {31'd0, early}, 32'd0);
    chk("t1_dets", dets, 32'd1);
    chk("t1_det_last", {31'd0, det_o}, 32'd1);
    chk("t1_done", {31'd0, done_o}, 32'd1);
    chk("t1_status", {30'd0, status_o}, 32'd1);
    chk("t1_cnt", {24'd0, match_cnt_o}, 32'd1);
    tick();
    chk("t1_done_off", {31'd0, done_o}, 32'd0);
    chk("t1_idle_busy", {31'd0, busy_o}, 32'd0);
    chk("t1_status_hold", {30'd0, status_o}, 32'd1);
    chk("t1_cnt_hold", {24'd0, match_cnt_o}, 32'd1);

    // 2: overlapping matches, target 2
    start_session(8'd2, 16'd0);
    feed(32'b111000000111000000111, 21, 1'b0, dets, early);
    chk("t2_early", {31'd0, early}, 32'd0);
    chk("t2_dets", dets, 32'd2);
    chk("t2_done", {31'd0, done_o}, 32'd1);
    chk("t2_status", {30'd0, status_o}, 32'd1);
    chk("t2_cnt", {24'd0, match_cnt_o}, 32'd2);
    tick();

    // 3: timeout after 10 bits
    start_session(8'd1, 16'd10);
    feed(32'b1111111111, 10, 1'b0, dets, early);
    chk("t3_early", {31'd0, early}, 32'd0);
    chk("t3_dets", dets, 32'd0);
    chk("t3_done", {31'd0, done_o}, 32'd1);
    chk("t3_status", {30'd0, status_o}, 32'd2);
    chk("t3_cnt", {24'd0, match_cnt_o}, 32'd0);
    tick();

    // 4: hit and timeout on the same bit, hit wins
    start_session(8'd1, 16'd12);
    feed(32'b111000000111, 12, 1'b0, dets, early);
    chk("t4_early", {31'd0, early}, 32'd0);
    chk("t4_done", {31'd0, done_o}, 32'd1);
    chk("t4_status", {30'd0, status_o}, 32'd1);
    chk("t4_cnt", {24'd0, match_cnt_o}, 32'd1);
    tick();

    // 5: abort on the final pattern bit, start while busy ignored
    start_session(8'd1, 16'd0);
    start_i = 1'b1; target_i = 8'd5;
    feed(32'b11100000011, 11, 1'b0, dets, early);
    start_i = 1'b0;
    chk("t5_busy_kept", {31'd0, busy_o}, 32'd1);
    chk("t5_early", {31'd0, early}, 32'd0);
    feed(32'b1, 1, 1'b1, dets, early);
    chk("t5_det", {31'd0, det_o}, 32'd0);
    chk("t5_done", {31'd0, done_o}, 32'd1);
    chk("t5_status", {30'd0, status_o}, 32'd3);
    chk("t5_cnt", {24'd0, match_cnt_o}, 32'd0);
    tick();
    chk("t5_idle", {31'd0, busy_o}, 32'd0);

    // 7: abort in RUN with no bit offered
    start_session(8'd3, 16'd0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t7_done", {31'd0, done_o}, 32'd1);
    chk("t7_status", {30'd0, status_o}, 32'd3);
    tick();

    // 6: reset mid-session, then a target-0 session
    start_session(8'd2, 16'd0);
    feed(32'b111000000111, 12, 1'b0, dets, early);
    chk("t6_pre_cnt", {24'd0, match_cnt_o}, 32'd1);
    chk("t6_pre_done", {31'd0, done_o}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_rst_ready", {31'd0, bit_ready_o}, 32'd0);
    chk("t6_rst_cnt", {24'd0, match_cnt_o}, 32'd0);
    chk("t6_rst_det", {31'd0, det_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_no_done", {31'd0, done_o}, 32'd0);
    start_i = 1'b1; target_i = 8'd0; timeout_i = 16'd0;
    tick();
    start_i = 1'b0;
    chk("t6_arm_done", {31'd0, done_o}, 32'd0);
    tick();
    chk("t6_done", {31'd0, done_o}, 32'd1);
    chk("t6_status", {30'd0, status_o}, 32'd1);
    chk("t6_cnt", {24'd0, match_cnt_o}, 32'd0);
    tick();
    chk("t6_done_off", {31'd0, done_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
